// File: rtl/chip8_frame_pkg.sv
// Shared constants, FSM state type and the bit-serial CRC-16 step for the
// CHIP-8 frame capture unit.
package chip8_frame_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SCAN    = 2'd2,
      DONE    = 2'd3
   } frame_state_e;

   // One data bit into the CRC, MSB-first, no reflection.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/chip8_frame_tick.sv
// Free-running frame tick: counts 0..FRAME_CYCLES-1 while enabled, pulses on the last count.
module chip8_frame_tick #(
   parameter int FRAME_CYCLES = 16666
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic tick
);

   localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (!enable || count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign tick = enable && (count == LAST);

endmodule

// File: rtl/chip8_frame_capture.sv
// Frame snapshot + CRC-16 signature unit for the CHIP-8 display bus.
// Optional row streaming handshake under macro CHIP8_FRAME_ROW_STREAM_EN.
module chip8_frame_capture
   import chip8_frame_pkg::*;
#(
   parameter int DISP_W       = 64,
   parameter int DISP_H       = 32,
   parameter int FRAME_CYCLES = 16666,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [DISP_W*DISP_H-1:0]   display,
   output logic                       busy,
   output logic                       frame_valid,
   output logic [15:0]                frame_crc,
   output logic                       frame_nonzero,
   output logic                       frame_changed,
   output logic [CNT_W-1:0]           frame_count,
   output logic                       overrun
`ifdef CHIP8_FRAME_ROW_STREAM_EN
   ,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic [DISP_W-1:0]          row_data,
   output logic [$clog2(DISP_H > 1 ? DISP_H : 2)-1:0] row_idx
`endif
);

   localparam int N  = DISP_W * DISP_H;
   localparam int RW = $clog2(DISP_H > 1 ? DISP_H : 2);
   localparam logic [RW-1:0] LAST_ROW = RW'(DISP_H - 1);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_CAPTURE = CAPTURE;
   localparam logic [1:0] ST_SCAN    = SCAN;
   localparam logic [1:0] ST_DONE    = DONE;

   logic              tick;
   logic              adv;
   logic [1:0]        state;
   logic [N-1:0]      snap;
   logic [15:0]       crc;
   logic [15:0]       crc_row;
   logic [RW-1:0]     row;
   logic              nz;
   logic              first;
   logic [DISP_W-1:0] cur_row;

   chip8_frame_tick #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .tick    (tick)
   );

   // The snapshot shifts up one row per scanned row, so the current row is always the top slice.
   assign cur_row = snap[N-1 -: DISP_W];
   assign busy    = (state != ST_IDLE);

`ifdef CHIP8_FRAME_ROW_STREAM_EN
   assign row_valid = (state == ST_SCAN);
   assign row_data  = cur_row;
   assign row_idx   = row;
   assign adv       = row_valid && row_ready;
`else
   assign adv       = 1'b1;
`endif

   // Whole row into the CRC in one cycle, pixel x=0 (row MSB) first.
   always_comb begin
      crc_row = crc;
      for (int i = DISP_W - 1; i >= 0; i--)
         crc_row = crc16_step(crc_row, cur_row[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         snap          <= '0;
         crc           <= CRC16_INIT;
         row           <= '0;
         nz            <= 1'b0;
         first         <= 1'b1;
         frame_valid   <= 1'b0;
         frame_crc     <= '0;
         frame_nonzero <= 1'b0;
         frame_changed <= 1'b0;
         frame_count   <= '0;
         overrun       <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (tick && state != ST_IDLE)
            overrun <= 1'b1;
         case (state)
            ST_IDLE: if (tick) state <= ST_CAPTURE;
            ST_CAPTURE: begin
               snap  <= display;
               crc   <= CRC16_INIT;
               row   <= '0;
               nz    <= 1'b0;
               state <= ST_SCAN;
            end
            ST_SCAN: if (adv) begin
               crc  <= crc_row;
               nz   <= nz | (|cur_row);
               snap <= snap << DISP_W;
               row  <= row + 1'b1;
               // Results land on the same edge that enters DONE, so they are valid with the strobe.
               if (row == LAST_ROW) begin
                  state         <= ST_DONE;
                  frame_valid   <= 1'b1;
                  frame_crc     <= crc_row;
                  frame_nonzero <= nz | (|cur_row);
                  frame_changed <= first || (crc_row != frame_crc);
                  frame_count   <= frame_count + 1'b1;
                  first         <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_frame_capture.sv
// Self-checking bench: cycle model of the main instance plus directed literal checks.
module tb_chip8_frame_capture;

   localparam int W = 64, H = 32, FC = 100, N = W * H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [N-1:0] d, input int n);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   logic rst_n = 1'b0;

   // main instance
   logic en_m = 1'b0;
   logic [N-1:0] disp_m = '0;
   logic busy_m, fv_m, nz_m, chg_m, ovr_m;
   logic [15:0] crc_m, cnt_m;
`ifdef CHIP8_FRAME_ROW_STREAM_EN
   logic rv_m, rr_m = 1'b1;
   logic [W-1:0] rd_m;
   logic [4:0] ri_m;
`endif

   chip8_frame_capture #(.DISP_W(W), .DISP_H(H), .FRAME_CYCLES(FC), .CNT_W(16)) u_main (
      .clk(clk), .reset_n(rst_n), .enable(en_m), .display(disp_m), .busy(busy_m),
      .frame_valid(fv_m), .frame_crc(crc_m), .frame_nonzero(nz_m), .frame_changed(chg_m),
      .frame_count(cnt_m), .overrun(ovr_m)
`ifdef CHIP8_FRAME_ROW_STREAM_EN
      , .row_valid(rv_m), .row_ready(rr_m), .row_data(rd_m), .row_idx(ri_m)
`endif
   );

   // small instance: 8x1, FRAME_CYCLES=16
   logic en_s = 1'b0;
   logic [7:0] disp_s = 8'h00;
   logic busy_s, fv_s, nz_s, chg_s, ovr_s;
   logic [15:0] crc_s, cnt_s;
`ifdef CHIP8_FRAME_ROW_STREAM_EN
   logic rv_s;
   logic [7:0] rd_s;
   logic [0:0] ri_s;
`endif

   chip8_frame_capture #(.DISP_W(8), .DISP_H(1), .FRAME_CYCLES(16), .CNT_W(16)) u_small (
      .clk(clk), .reset_n(rst_n), .enable(en_s), .display(disp_s), .busy(busy_s),
      .frame_valid(fv_s), .frame_crc(crc_s), .frame_nonzero(nz_s), .frame_changed(chg_s),
      .frame_count(cnt_s), .overrun(ovr_s)
`ifdef CHIP8_FRAME_ROW_STREAM_EN
      , .row_valid(rv_s), .row_ready(1'b1), .row_data(rd_s), .row_idx(ri_s)
`endif
   );

   // overlapping-tick instance: FRAME_CYCLES=20 < DISP_H+3
   logic en_o = 1'b0;
   logic [N-1:0] disp_o = '0;
   logic busy_o, fv_o, nz_o, chg_o, ovr_o;
   logic [15:0] crc_o, cnt_o;
`ifdef CHIP8_FRAME_ROW_STREAM_EN
   logic rv_o;
   logic [W-1:0] rd_o;
   logic [4:0] ri_o;
`endif

   chip8_frame_capture #(.DISP_W(W), .DISP_H(H), .FRAME_CYCLES(20), .CNT_W(16)) u_ovr (
      .clk(clk), .reset_n(rst_n), .enable(en_o), .display(disp_o), .busy(busy_o),
      .frame_valid(fv_o), .frame_crc(crc_o), .frame_nonzero(nz_o), .frame_changed(chg_o),
      .frame_count(cnt_o), .overrun(ovr_o)
`ifdef CHIP8_FRAME_ROW_STREAM_EN
      , .row_valid(rv_o), .row_ready(1'b1), .row_data(rd_o), .row_idx(ri_o)
`endif
   );

   // ---- model of u_main: e_* hold what the outputs must be in the current cycle ----
   int m_cnt = 0, m_rows_left = 0;
   bit m_cap = 0, m_first = 1;
   logic [N-1:0] m_snap = '0;
   logic [15:0] e_crc = '0, e_cnt = '0;
   bit e_valid = 0, e_nz = 0, e_chg = 0, e_ovr = 0;

   always @(negedge clk) begin
      bit tk, bz, rdy;
      logic [15:0] c;
      if (!rst_n) begin
         m_cnt = 0; m_rows_left = 0; m_cap = 0; m_first = 1; m_snap = '0;
         e_crc = '0; e_cnt = '0; e_valid = 0; e_nz = 0; e_chg = 0; e_ovr = 0;
      end
      bz = m_cap || (m_rows_left > 0) || e_valid;
      check("busy", 64'(busy_m), 64'(bz));
      check("frame_valid", 64'(fv_m), 64'(e_valid));
      check("frame_crc", 64'(crc_m), 64'(e_crc));
      check("frame_nonzero", 64'(nz_m), 64'(e_nz));
      check("frame_changed", 64'(chg_m), 64'(e_chg));
      check("frame_count", 64'(cnt_m), 64'(e_cnt));
      check("overrun", 64'(ovr_m), 64'(e_ovr));
`ifdef CHIP8_FRAME_ROW_STREAM_EN
      check("row_valid", 64'(rv_m), 64'(m_rows_left > 0));
      if (m_rows_left > 0) begin
         check("row_idx", 64'(ri_m), 64'(H - m_rows_left));
         check("row_data", 64'(rd_m), 64'(m_snap[(m_rows_left - 1) * W +: W]));
      end
      rdy = rr_m;
`else
      rdy = 1'b1;
`endif
      if (rst_n) begin
         tk = en_m && (m_cnt == FC - 1);
         if (tk && bz) e_ovr = 1;
         m_cnt = (!en_m || m_cnt == FC - 1) ? 0 : m_cnt + 1;
         e_valid = 0;
         if (m_rows_left > 0 && rdy) begin
            m_rows_left--;
            if (m_rows_left == 0) begin
               c = crc_model(m_snap, N);
               e_chg = m_first || (c != e_crc);
               e_crc = c; e_nz = |m_snap; e_cnt++; m_first = 0; e_valid = 1;
            end
         end
         if (m_cap) begin
            m_snap = disp_m; m_rows_left = H; m_cap = 0;
         end else if (tk && !bz) m_cap = 1;
      end
   end

   // Waits for the next frame of u_main; lat = cycles from first busy cycle to the strobe.
   task automatic wait_strobe(output int lat);
      int n;
      lat = -1;
      n = 0;
      @(negedge clk);
      while (!busy_m && n < 400) begin @(negedge clk); n++; end
      if (!busy_m) begin check("busy_timeout", 64'(0), 64'(1)); return; end
      n = 0;
      while (!fv_m && n < 400) begin @(negedge clk); n++; end
      if (!fv_m) begin check("strobe_timeout", 64'(0), 64'(1)); return; end
      lat = n;
   endtask

   // Returns at a posedge whose following cycle scans row r of u_main.
   task automatic wait_row(input int r);
      int n;
      n = 0;
      do begin @(posedge clk); n++; end
      while (!(m_rows_left > 0 && H - m_rows_left == r) && n < 400);
      if (n >= 400) check("row_timeout", 64'(0), 64'(1));
   endtask

   logic [N-1:0] pa, pb, tmp;
   bit tog;
   int lat, seen, first_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N / 64; i++) pa[i * 64 +: 64] = 64'hDEADBEEF_01234567 ^ 64'(i);
      pb = ~pa;

      // model pins: CRC-16/CCITT-FALSE reference values
      tmp = '0;
      check("pin_00", 64'(crc_model(tmp, 8)), 64'h0000_0000_0000_E1F0);
      tmp[71:0] = 72'h31_32_33_34_35_36_37_38_39;
      check("pin_123456789", 64'(crc_model(tmp, 72)), 64'h0000_0000_0000_29B1);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_small_cnt", 64'(cnt_s), 64'(0));
      check("rst_small_crc", 64'(crc_s), 64'(0));

      // known vector on the 8x1 instance
      @(posedge clk); #1 en_s = 1'b1;
      seen = 0; first_i = -1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (fv_s) begin
            seen++;
            if (first_i < 0) first_i = i;
            check("small_crc", 64'(crc_s), 64'hE1F0);
            check("small_nz", 64'(nz_s), 64'(0));
            check("small_chg", 64'(chg_s), 64'(1));
            check("small_cnt", 64'(cnt_s), 64'(1));
         end
      end
      check("small_latency", 64'(first_i), 64'(18));
      check("small_strobes", 64'(seen), 64'(1));
      en_s = 1'b0;

      // overlapping ticks: dropped ticks raise overrun and add no strobe
      @(posedge clk); #1 en_o = 1'b1;
      seen = 0; first_i = -1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (fv_o) begin seen++; if (first_i < 0) first_i = i; end
         if (i == 39) check("ovr_before", 64'(ovr_o), 64'(0));
         if (i == 40) check("ovr_after", 64'(ovr_o), 64'(1));
      end
      check("ovr_first_strobe", 64'(first_i), 64'(53));
      check("ovr_strobes", 64'(seen), 64'(2));
      check("ovr_cnt", 64'(cnt_o), 64'(2));
      en_o = 1'b0;

      // main: two blank frames, then pixel (0,0)
      @(posedge clk); #1 en_m = 1'b1; disp_m = '0;
      tmp = '0;
      wait_strobe(lat);
      check("f1_lat", 64'(lat), 64'(33));
      check("f1_cnt", 64'(cnt_m), 64'(1));
      check("f1_chg", 64'(chg_m), 64'(1));
      check("f1_nz", 64'(nz_m), 64'(0));
      check("f1_crc", 64'(crc_m), 64'(crc_model(tmp, N)));
      wait_strobe(lat);
      check("f2_cnt", 64'(cnt_m), 64'(2));
      check("f2_chg", 64'(chg_m), 64'(0));
      check("f2_crc", 64'(crc_m), 64'(crc_model(tmp, N)));
      @(posedge clk); #1 disp_m[N-1] = 1'b1;
      tmp[N-1] = 1'b1;
      wait_strobe(lat);
      check("f3_cnt", 64'(cnt_m), 64'(3));
      check("f3_chg", 64'(chg_m), 64'(1));
      check("f3_nz", 64'(nz_m), 64'(1));
      check("f3_crc", 64'(crc_m), 64'(crc_model(tmp, N)));

      // enable drop clears the tick counter
      @(posedge clk); #1 en_m = 1'b0;
      repeat (30) @(posedge clk);
      #1 en_m = 1'b1;

      // display toggling every cycle: only the capture-cycle value counts
      tog = 1'b1;
      fork
         begin
            while (tog) begin @(posedge clk); #1 disp_m = (disp_m == pa) ? pb : pa; end
         end
         begin
            wait_strobe(lat);
            tog = 1'b0;
         end
      join
      check("f4_cnt", 64'(cnt_m), 64'(4));
      check("f4_crc_ab", 64'(crc_m == crc_model(pa, N) || crc_m == crc_model(pb, N)), 64'(1));

      // reset in the middle of the scan
      @(posedge clk); #1 disp_m = pa;
      wait_row(10);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("rst_cnt", 64'(cnt_m), 64'(0));
      check("rst_fv", 64'(fv_m), 64'(0));
      check("rst_crc", 64'(crc_m), 64'(0));
      check("rst_busy", 64'(busy_m), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_strobe(lat);
      check("f5_lat", 64'(lat), 64'(33));
      check("f5_cnt", 64'(cnt_m), 64'(1));
      check("f5_chg", 64'(chg_m), 64'(1));
      check("f5_crc", 64'(crc_m), 64'(crc_model(pa, N)));

`ifdef CHIP8_FRAME_ROW_STREAM_EN
      // 5-cycle stall at row 3
      fork
         wait_strobe(lat);
         begin
            wait_row(3);
            #1 rr_m = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_idx", 64'(ri_m), 64'(3));
               check("stall_data", 64'(rd_m), 64'(pa[(H - 1 - 3) * W +: W]));
            end
            @(posedge clk); #1 rr_m = 1'b1;
         end
      join
      check("stall_lat", 64'(lat), 64'(38));
      check("stall_chg", 64'(chg_m), 64'(0));
      check("stall_crc", 64'(crc_m), 64'(crc_model(pa, N)));
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/chip8_frame_capture.md
Name: chip8_frame_capture

Overview:
- Parametrised frame-snapshot and signature unit for the CHIP-8 display bus.
- Generates its own frame tick every FRAME_CYCLES clocks and registers a snapshot of the display vector.
- Scans the snapshot one row per cycle into a CRC-16, then pulses a per-frame result: CRC, non-zero flag, changed flag and frame count.
- Sits beside chip8_top, so frame checking is done in hardware instead of by file dumps.

Parameters:
- DISP_W, 64, pixels per row.
- DISP_H, 32, number of rows.
- FRAME_CYCLES, 16666, clocks per frame tick. Must be greater than DISP_H+3.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  runs the frame tick counter.
- display  in  DISP_W*DISP_H  framebuffer. Row r = display[(DISP_H-1-r)*DISP_W +: DISP_W]. Row 0 is the MSBs; bit DISP_W-1 of a row is pixel x=0.
- busy  out  1  capture or scan in progress.
- frame_valid  out  1  one-cycle result strobe.
- frame_crc  out  16  CRC of the last completed frame.
- frame_nonzero  out  1  last frame had any pixel set.
- frame_changed  out  1  last CRC differs from the previous one, or this is the first frame since reset.
- frame_count  out  CNT_W  number of frames completed.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - all outputs 0; tick counter 0; state IDLE; snapshot 0; "first frame" flag set.
  - A reset mid-scan aborts with no frame_valid.
- Tick counter:
  - When enable=1, counts 0..FRAME_CYCLES-1 and wraps.
  - tick=1 in the cycle where the count equals FRAME_CYCLES-1.
  - When enable=0, the count is cleared to 0 and no ticks occur. A scan already in progress still completes.
- FSM states: IDLE, CAPTURE, SCAN, DONE.
  - IDLE: tick -> CAPTURE.
  - CAPTURE, 1 cycle: register display into the snapshot, crc<=16'hFFFF, row<=0, nz<=0.
  - SCAN, DISP_H cycles: per cycle, crc <= crc16 over the DISP_W bits of row[row], MSB first; nz |= |row; row++. After row DISP_H-1 -> DONE.
  - DONE, 1 cycle: frame_valid=1 and all result outputs update on the same edge; frame_count++ (wraps modulo 2^CNT_W); clear the "first" flag -> IDLE.
- Latency: a tick in cycle T gives frame_valid high in cycle T+DISP_H+2.
- busy is high in CAPTURE, SCAN and DONE.
- CRC algorithm: poly 0x1021, init 0xFFFF per frame, no reflection, no final xor.
  - Bit-serial reference: fb=crc[15]^d; crc=(crc<<1)^(fb?0x1021:0).
  - Implemented DISP_W bits in parallel per cycle.
- The display may change during SCAN; only the CAPTURE-cycle value is used.
- Tick while busy: the tick is dropped and overrun<=1. overrun clears only on reset.
- frame_crc, frame_nonzero and frame_changed hold their values between strobes.

Optional Feature:
- Macro: CHIP8_FRAME_ROW_STREAM_EN.
- Defined — adds four ports:
  - row_valid out 1.
  - row_ready in 1.
  - row_data out DISP_W.
  - row_idx out $clog2(DISP_H).
- Defined — streaming behaviour:
  - In SCAN, row_valid=1 with the current row.
  - The row and the CRC advance only when row_valid&&row_ready.
  - row_data and row_idx are held stable while stalled.
  - Latency becomes T+2+(cycles to complete DISP_H handshakes).
  - A tick while stalled sets overrun.
- Not defined: none of these ports exist and SCAN never stalls.

Decomposition:
- Package chip8_frame_pkg holds:
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
  - the state enum typedef {IDLE,CAPTURE,SCAN,DONE};
  - function crc16_step(crc, bit).
- Sub-module chip8_frame_tick: counter plus tick generation (enable, FRAME_CYCLES). The parallel-row CRC is a loop over crc16_step inside the main module.

Test Plan:
- Known vector. DISP_W=8, DISP_H=1, FRAME_CYCLES=16, display=8'h00, enable=1 -> frame_valid in cycle T+3; frame_crc=16'hE1F0; frame_nonzero=0; frame_changed=1; frame_count=1.
- Defaults, display all zero for two frames, then pixel (0,0) set (bit 2047) -> frame 2 changed=0, same CRC; frame 3 nonzero=1, changed=1, CRC matches the bench bit-serial model; frame_count=3.
- Pulse reset_n low during SCAN, row 10 -> no frame_valid, outputs 0, frame_count=0; the next frame reports changed=1.
- FRAME_CYCLES=20, DISP_H=32 (illegal, so ticks overlap) -> overrun=1 after the second tick; a frame_valid still occurs per completed scan; a dropped tick produces no extra strobe.
- Toggle display every cycle during SCAN -> CRC equals the model of the CAPTURE-cycle value.
- With CHIP8_FRAME_ROW_STREAM_EN: row_ready low for 5 cycles at row 3 -> row_idx holds 3 with stable row_data; latency grows by 5; CRC unchanged versus no stall.
